bbox_digit_overlay: RTL

- Stage directly downstream of the image-processing stage (edge tracking + digit recognition).
- Consumes the video stream plus the per-frame bounding box (left/right/top/bottom) and recognised digit (num).
- Outputs the same stream delayed by 2 clocks, with a rectangle drawn around the detected object and the filtered digit rendered as a 7-segment glyph.
- Feeds the RGB-to-DVI output encoder.

---
 rtl/bbox_digit_overlay.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/bbox_digit_overlay.sv
// bbox_digit_overlay: two-stage video overlay that draws the per-frame bounding box
// and a vsync-filtered 7-segment digit on top of the source stream.
module bbox_digit_overlay #(
  parameter int          LINE_W        = 2,
  parameter logic [23:0] BOX_COLOR     = 24'hFF0000,
  parameter logic [23:0] DIGIT_COLOR   = 24'h00FF00,
  parameter int          DIGIT_X       = 16,
  parameter int          DIGIT_Y       = 16,
  parameter int          SEG_LEN       = 24,
  parameter int          SEG_W         = 4,
  parameter int          STABLE_FRAMES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] RGB_Data_Src,
  input  logic        RGB_HSync_Src,
  input  logic        RGB_VSync_Src,
  input  logic        RGB_VDE_Src,
  input  logic [10:0] RGB_x_Src,
  input  logic [9:0]  RGB_y_Src,
  input  logic [10:0] left,
  input  logic [10:0] right,
  input  logic [9:0]  top,
  input  logic [9:0]  bottom,
  input  logic [3:0]  num,
  output logic [23:0] RGB_Data_Out,
  output logic        RGB_HSync_Out,
  output logic        RGB_VSync_Out,
  output logic        RGB_VDE_Out,
  output logic [3:0]  digit_shown
);
  localparam logic [11:0] LWX = 12'(LINE_W);
  localparam logic [11:0] DXO = 12'(DIGIT_X);
  localparam logic [11:0] WX  = 12'(SEG_W);
  localparam logic [11:0] LX  = 12'(SEG_LEN);
  localparam logic [10:0] LWY = 11'(LINE_W);
  localparam logic [10:0] DYO = 11'(DIGIT_Y);
  localparam logic [10:0] WY  = 11'(SEG_W);
  localparam logic [10:0] LY  = 11'(SEG_LEN);
  localparam logic [3:0]  SF  = 4'(STABLE_FRAMES);
  // Segment bits {a,b,c,d,e,f,g}; entries 10..15 draw nothing.
  localparam logic [6:0] SEG_MAP [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F,
                                          7'h70, 7'h7F, 7'h7B, 7'h00, 7'h00, 7'h00, 7'h00,
                                          7'h00, 7'h00};
  logic [23:0] data1_q, data1_d, out_q, out_d;
  logic        hs1_q, hs1_d, vs1_q, vs1_d, de1_q, de1_d;
  logic        hs2_q, hs2_d, vs2_q, vs2_d, de2_q, de2_d;
  logic        vsp_q, vsp_d, bv_q, bv_d;
  logic [10:0] x1_q, x1_d, l_q, l_d, r_q, r_d;
  logic [9:0]  y1_q, y1_d, t_q, t_d, b_q, b_d;
  logic [3:0]  cand_q, cand_d, cnt_q, cnt_d, shown_q, shown_d;
  logic        rise, box_hit, seg_hit, hx, lc, rc, up, lo;
  logic [11:0] xe, le, re, dx;
  logic [10:0] ye, te, be, dy;
  logic [6:0]  on;
  always_comb begin
    rise    = RGB_VSync_Src & ~vsp_q;
    vsp_d   = RGB_VSync_Src;
    data1_d = RGB_Data_Src;
    hs1_d   = RGB_HSync_Src;
    vs1_d   = RGB_VSync_Src;
    de1_d   = RGB_VDE_Src;
    x1_d    = RGB_x_Src;
    y1_d    = RGB_y_Src;
    hs2_d   = hs1_q;
    vs2_d   = vs1_q;
    de2_d   = de1_q;
    l_d     = rise ? left   : l_q;
    r_d     = rise ? right  : r_q;
    t_d     = rise ? top    : t_q;
    b_d     = rise ? bottom : b_q;
    bv_d    = rise ? (left < right && top < bottom) : bv_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    shown_d = shown_q;
    if (rise) begin
      cand_d  = num;
      cnt_d   = (num != cand_q) ? 4'd1 : (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
      shown_d = (cnt_d == SF) ? ((num > 4'd9) ? 4'hF : num) : shown_q;
    end
    xe = {1'b0, x1_q};
    le = {1'b0, l_q};
    re = {1'b0, r_q};
    ye = {1'b0, y1_q};
    te = {1'b0, t_q};
    be = {1'b0, b_q};
    // Edge band of the box; a box thinner than two line widths becomes solid.
    box_hit = bv_q && xe >= le && xe <= re && ye >= te && ye <= be &&
              (xe < le + LWX || xe + LWX > re || ye < te + LWY || ye + LWY > be);
    dx = xe - DXO;
    dy = ye - DYO;
    hx = dx >= WX && dx < WX + LX;
    lc = dx < WX;
    rc = dx >= LX + WX && dx < LX + WX + WX;
    up = dy >= WY && dy < WY + LY;
    lo = dy >= LY + WY + WY && dy < LY + LY + WY + WY;
    on = {hx && dy < WY, rc && up, rc && lo,
          hx && dy >= LY + LY + WY + WY && dy < LY + LY + WY + WY + WY,
          lc && lo, lc && up, hx && dy >= LY + WY && dy < LY + WY + WY};
    seg_hit = xe >= DXO && ye >= DYO && |(SEG_MAP[shown_q] & on);
    out_d = de1_q ? (seg_hit ? DIGIT_COLOR : box_hit ? BOX_COLOR : data1_q) : 24'h0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data1_q <= '0;
      out_q   <= '0;
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      de1_q   <= 1'b0;
      hs2_q   <= 1'b0;
      vs2_q   <= 1'b0;
      de2_q   <= 1'b0;
      vsp_q   <= 1'b0;
      bv_q    <= 1'b0;
      x1_q    <= '0;
      y1_q    <= '0;
      l_q     <= '0;
      r_q     <= '0;
      t_q     <= '0;
      b_q     <= '0;
      cand_q  <= 4'hF;
      cnt_q   <= 4'd0;
      shown_q <= 4'hF;
    end else begin
      data1_q <= data1_d;
      out_q   <= out_d;
      hs1_q   <= hs1_d;
      vs1_q   <= vs1_d;
      de1_q   <= de1_d;
      hs2_q   <= hs2_d;
      vs2_q   <= vs2_d;
      de2_q   <= de2_d;
      vsp_q   <= vsp_d;
      bv_q    <= bv_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      l_q     <= l_d;
      r_q     <= r_d;
      t_q     <= t_d;
      b_q     <= b_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      shown_q <= shown_d;
    end
  end
  assign RGB_Data_Out  = out_q;
  assign RGB_HSync_Out = hs2_q;
  assign RGB_VSync_Out = vs2_q;
  assign RGB_VDE_Out   = de2_q;
  assign digit_shown   = shown_q;
endmodule
